// File: rtl/cp_inserter_pkg.sv
// Shared settings addresses, default lengths, read FSM states and bank descriptor for the
// OFDM cyclic-prefix inserter.
package cp_inserter_pkg;

  localparam logic [7:0] SR_FRAME_LEN = 8'h10;
  localparam logic [7:0] SR_CP_LEN    = 8'h11;

  localparam int unsigned MAX_LEN_LOG2 = 12;
  localparam int unsigned LEN_W        = MAX_LEN_LOG2 + 1;

  localparam logic [LEN_W-1:0] DEFAULT_FRAME_LEN = LEN_W'(64);
  localparam logic [LEN_W-1:0] DEFAULT_CP_LEN    = LEN_W'(16);

  typedef enum logic [1:0] {
    StIdle,
    StCp,
    StBody
  } rd_state_e;

  typedef struct packed {
    logic [LEN_W-1:0] flen;
    logic [LEN_W-1:0] cplen;
  } bank_desc_t;

  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// AXI-Stream sample channel used on both sides of the CP inserter.
interface ofdm_cp_inserter_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);

endinterface

// File: rtl/cp_pingpong_ram.sv
// Simple dual-port sample RAM holding two symbol banks; bank select is the address MSB.
module cp_pingpong_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BankAw = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BankAw:0]   waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [BankAw:0]   raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int unsigned Depth = 2 * (2 ** BankAw);

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofdm_cp_inserter.sv
// Buffers OFDM symbols in a ping-pong RAM and emits each as cyclic prefix + full symbol.
// MAX_LEN_LOG2 must not exceed the package value, which sizes the descriptor fields.
module ofdm_cp_inserter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_LEN_LOG2 = cp_inserter_pkg::MAX_LEN_LOG2,
  parameter logic [7:0]  SR_FRAME_LEN = cp_inserter_pkg::SR_FRAME_LEN,
  parameter logic [7:0]  SR_CP_LEN    = cp_inserter_pkg::SR_CP_LEN
) (
  input  logic                ce_clk,
  input  logic                ce_rst,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  ofdm_cp_inserter_if.slave   i_axis,
  ofdm_cp_inserter_if.master  o_axis,
  output logic                err_tlast,
  input  logic                clear_err
);

  import cp_inserter_pkg::*;

  localparam int unsigned AW     = MAX_LEN_LOG2;
  localparam int unsigned MaxLen = 2 ** MAX_LEN_LOG2;

  typedef logic [LEN_W-1:0] len_t;
  typedef logic [AW-1:0]    addr_t;

  function automatic addr_t start_addr(input bank_desc_t d);
    len_t s;
    s = (d.cplen == '0) ? '0 : (d.flen - d.cplen);
    return s[AW-1:0];
  endfunction

  len_t       frame_len_q, frame_len_d, cp_len_q, cp_len_d;
  bank_desc_t desc_q [2];
  bank_desc_t desc_d [2];
  logic [1:0] full_q, full_d;
  logic       rdy_en_q;
  logic       err_q, err_d;
  logic       wr_bank_q, wr_bank_d;
  addr_t      wr_cnt_q, wr_cnt_d;
  rd_state_e  state_q, state_d;
  logic       rd_bank_q, rd_bank_d;
  addr_t      rd_addr_q, rd_addr_d;
  logic       rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [WIDTH-1:0] sk_data_q [2];
  logic [WIDTH-1:0] sk_data_d [2];
  logic [1:0] sk_last_q, sk_last_d;
  logic       sk_wptr_q, sk_wptr_d, sk_rptr_q, sk_rptr_d;
  logic [1:0] sk_cnt_q, sk_cnt_d;

  logic       wr_fire, wr_last, full_set, rd_done;
  len_t       wr_flen;
  logic       active, phase_cp, issue, at_end, pop, space;
  addr_t      cur;
  bank_desc_t rd_desc, oth_desc;
  logic [2:0] occ;
  logic [WIDTH-1:0] ram_rdata;

  always_comb begin : p_settings
    frame_len_d = frame_len_q;
    cp_len_d    = cp_len_q;
    if (set_stb && set_addr == SR_FRAME_LEN && set_data != 32'd0 && set_data <= 32'(MaxLen)) begin
      frame_len_d = len_t'(set_data);
    end
    // Saturating keeps min(cp_len, frame_len) exact for any frame_len in range.
    if (set_stb && set_addr == SR_CP_LEN) begin
      cp_len_d = (set_data > 32'(MaxLen)) ? len_t'(MaxLen) : len_t'(set_data);
    end
  end

  assign i_axis.tready = rdy_en_q && !full_q[wr_bank_q];
  assign wr_fire       = i_axis.tvalid && i_axis.tready;
  assign wr_flen       = (wr_cnt_q == '0) ? frame_len_q : desc_q[wr_bank_q].flen;
  assign wr_last       = (len_t'(wr_cnt_q) == wr_flen - len_t'(1));

  always_comb begin : p_write
    desc_d    = desc_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = 1'b0;
    err_d     = err_q && !clear_err;
    if (wr_fire) begin
      if (wr_cnt_q == '0) begin
        desc_d[wr_bank_q] = '{flen: frame_len_q, cplen: min_len(cp_len_q, frame_len_q)};
      end
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
        full_set  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + addr_t'(1);
      end
      if (i_axis.tlast != wr_last) err_d = 1'b1;
    end
  end

  assign rd_desc  = desc_q[rd_bank_q];
  assign oth_desc = desc_q[~rd_bank_q];
  assign pop      = (sk_cnt_q != 2'd0) && o_axis.tready;
  assign occ      = 3'(sk_cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign space    = (occ < 3'd2);

  // IDLE issues the first read itself so the prefix starts without a bubble.
  always_comb begin : p_read
    active    = 1'b0;
    phase_cp  = 1'b0;
    cur       = rd_addr_q;
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_done   = 1'b0;
    full_d    = full_q;
    unique case (state_q)
      StIdle: begin
        active   = full_q[rd_bank_q];
        phase_cp = (rd_desc.cplen != '0);
        cur      = start_addr(rd_desc);
      end
      StCp: begin
        active   = 1'b1;
        phase_cp = 1'b1;
      end
      StBody: begin
        active   = 1'b1;
      end
      default: ;
    endcase
    issue  = active && space;
    at_end = (len_t'(cur) == rd_desc.flen - len_t'(1));
    if (issue) begin
      if (phase_cp) begin
        state_d   = at_end ? StBody : StCp;
        rd_addr_d = at_end ? '0 : cur + addr_t'(1);
      end else if (at_end) begin
        rd_done   = 1'b1;
        rd_bank_d = ~rd_bank_q;
        if (full_q[~rd_bank_q]) begin
          state_d   = (oth_desc.cplen != '0) ? StCp : StBody;
          rd_addr_d = start_addr(oth_desc);
        end else begin
          state_d   = StIdle;
          rd_addr_d = '0;
        end
      end else begin
        state_d   = StBody;
        rd_addr_d = cur + addr_t'(1);
      end
    end
    rd_vld_d  = issue;
    rd_last_d = issue && !phase_cp && at_end;
    // Writer and reader always touch different banks here.
    if (full_set) full_d[wr_bank_q] = 1'b1;
    if (rd_done)  full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin : p_skid
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    sk_wptr_d = sk_wptr_q;
    sk_rptr_d = sk_rptr_q;
    if (rd_vld_q) begin
      sk_data_d[sk_wptr_q] = ram_rdata;
      sk_last_d[sk_wptr_q] = rd_last_q;
      sk_wptr_d            = ~sk_wptr_q;
    end
    if (pop) sk_rptr_d = ~sk_rptr_q;
    sk_cnt_d = sk_cnt_q + 2'(rd_vld_q) - 2'(pop);
  end

  assign o_axis.tvalid = (sk_cnt_q != 2'd0);
  assign o_axis.tdata  = sk_data_q[sk_rptr_q];
  assign o_axis.tlast  = sk_last_q[sk_rptr_q];
  assign err_tlast     = err_q;

  cp_pingpong_ram #(
    .WIDTH  (WIDTH),
    .BankAw (AW)
  ) u_ram (
    .clk_i   (ce_clk),
    .we_i    (wr_fire),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (i_axis.tdata),
    .re_i    (issue),
    .raddr_i ({rd_bank_q, cur}),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      frame_len_q <= DEFAULT_FRAME_LEN;
      cp_len_q    <= DEFAULT_CP_LEN;
      desc_q      <= '{default: '0};
      full_q      <= '0;
      rdy_en_q    <= 1'b0;
      err_q       <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      state_q     <= StIdle;
      rd_bank_q   <= 1'b0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      sk_data_q   <= '{default: '0};
      sk_last_q   <= '0;
      sk_wptr_q   <= 1'b0;
      sk_rptr_q   <= 1'b0;
      sk_cnt_q    <= '0;
    end else begin
      frame_len_q <= frame_len_d;
      cp_len_q    <= cp_len_d;
      desc_q      <= desc_d;
      full_q      <= full_d;
      rdy_en_q    <= 1'b1;
      err_q       <= err_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
      sk_wptr_q   <= sk_wptr_d;
      sk_rptr_q   <= sk_rptr_d;
      sk_cnt_q    <= sk_cnt_d;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Scoreboard bench for ofdm_cp_inserter: symbol-level reference model feeds an expected queue,
// an independent monitor checks every output handshake.
module tb_ofdm_cp_inserter;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        set_stb, clear_err, err_tlast;
  logic [7:0]  set_addr;
  logic [31:0] set_data;

  ofdm_cp_inserter_if #(.WIDTH(32)) in_if ();
  ofdm_cp_inserter_if #(.WIDTH(32)) out_if ();

  ofdm_cp_inserter dut (
    .ce_clk    (ce_clk),
    .ce_rst    (ce_rst),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .i_axis    (in_if),
    .o_axis    (out_if),
    .err_tlast (err_tlast),
    .clear_err (clear_err)
  );

  always #5 ce_clk = ~ce_clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   mdl_flen = 64, mdl_cp = 16;
  int   cyc = 0, acc_cyc = 0, first_vld_cyc = -1;
  int   sym_in = 0, sym_out = 0;
  int   win_n = 0, win_first = 0, win_last = 0;
  bit   lat_arm = 0, ready_chk = 0, rnd_ready = 0, hold_pend = 0;
  logic [32:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge ce_clk) cyc++;

  always @(posedge ce_clk) begin
    #1;
    out_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: compares every accepted beat against the expected queue.
  always @(negedge ce_clk) begin
    if (!ce_rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_if.tvalid, 1);
        check("hold_data", {out_if.tlast, out_if.tdata}, held);
      end
      if (ready_chk && !in_if.tready) check("stall_only_both_full", (sym_in - sym_out) >= 2, 1);
      if (lat_arm && out_if.tvalid) begin
        first_vld_cyc = cyc;
        lat_arm = 0;
      end
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %0h, expected no output", out_if.tdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_if.tdata, e.d);
          check("out_last", out_if.tlast, e.l);
          if (e.l) sym_out++;
        end
        if (win_n == 0) win_first = cyc;
        win_last = cyc;
        win_n++;
      end
      hold_pend = out_if.tvalid && !out_if.tready;
      held      = {out_if.tlast, out_if.tdata};
    end
  end

  task automatic wr_set(input logic [7:0] a, input int d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    @(posedge ce_clk); #1;
    set_stb  = 1'b0;
    if (a == 8'h10 && d >= 1 && d <= 4096) mdl_flen = d;
    if (a == 8'h11) mdl_cp = d;
  endtask

  // Sends one symbol; the model expects the last min(cp,flen) samples followed by all of them.
  task automatic send_symbol(input int base, input int err_idx, input bit rnd, input int wr_at,
                             input logic [7:0] wa, input int wd, input bit clr, input bit keep,
                             input int len);
    int n, cp, t;
    bit ok;
    n  = (len > 0) ? len : mdl_flen;
    cp = (mdl_cp < mdl_flen) ? mdl_cp : mdl_flen;
    if (keep) begin
      for (int i = n - cp; i < n; i++) exp_q.push_back('{d: base + i, l: 1'b0});
      for (int i = 0; i < n; i++) exp_q.push_back('{d: base + i, l: (i == n - 1)});
    end
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) wr_set(wa, wd);
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge ce_clk); #1; end
      in_if.tdata  = base + i;
      in_if.tlast  = (i == n - 1) ^ (i == err_idx);
      in_if.tvalid = 1'b1;
      clear_err    = clr && (i == err_idx);
      ok = 0;
      t  = 0;
      while (!ok && t < 4000) begin
        @(negedge ce_clk);
        if (in_if.tready) ok = 1;
        else t++;
      end
      check("in_accept", ok, 1);
      @(posedge ce_clk); #1;
      in_if.tvalid = 1'b0;
      in_if.tlast  = 1'b0;
      clear_err    = 1'b0;
      if (i == n - 1 && keep) begin
        sym_in++;
        acc_cyc = cyc;
      end
    end
  endtask

  task automatic send(input int base);
    send_symbol(base, -1, 0, -1, 8'h00, 0, 0, 1, 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge ce_clk); #1;
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (4) begin @(posedge ce_clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    set_stb = 0; set_addr = 0; set_data = 0; clear_err = 0;
    in_if.tvalid = 0; in_if.tdata = 0; in_if.tlast = 0;
    #2 ce_rst = 1'b0;
    repeat (3) @(posedge ce_clk);
    #2;
    check("rst_i_tready", in_if.tready, 0);
    check("rst_o_tvalid", out_if.tvalid, 0);
    check("rst_o_tlast", out_if.tlast, 0);
    check("rst_o_tdata", out_if.tdata, 0);
    check("rst_err", err_tlast, 0);
    @(negedge ce_clk);
    ce_rst = 1'b1;
    #1 check("rdy_at_release", in_if.tready, 0);
    @(posedge ce_clk); #1;
    check("rdy_one_cycle_after", in_if.tready, 1);

    // Single symbol with default lengths and latency.
    lat_arm = 1;
    send(0);
    wait_drain();
    check("first_out_latency", first_vld_cyc - acc_cyc, 2);
    check("err_clean", err_tlast, 0);

    // Back-to-back symbols: contiguous output.
    win_n = 0;
    for (int k = 0; k < 4; k++) send(100 * k);
    wait_drain();
    check("b2b_count", win_n, 320);
    check("b2b_no_gaps", win_last - win_first + 1, 320);

    // Random valid/ready with hold and stall checks.
    rnd_ready = 1;
    ready_chk = 1;
    for (int k = 0; k < 4; k++) send_symbol(100 * k, -1, 1, -1, 8'h00, 0, 0, 1, 0);
    wait_drain();
    ready_chk = 0;
    rnd_ready = 0;

    // Length settings: ignored frame_len writes, no CP, full-length CP, mid-symbol write.
    wr_set(8'h10, 0);
    wr_set(8'h10, 5000);
    wr_set(8'h11, 0);
    send(1000);
    wait_drain();
    wr_set(8'h10, 8);
    wr_set(8'h11, 8);
    send(2000);
    wr_set(8'h11, 100);
    send(3000);
    wait_drain();
    wr_set(8'h10, 64);
    wr_set(8'h11, 16);
    send_symbol(4000, -1, 0, 20, 8'h11, 20, 0, 1, 0);
    send(5000);
    wait_drain();

    // tlast error flag: set, sticky, clear, and clear colliding with a new error.
    wr_set(8'h11, 16);
    send_symbol(6000, 10, 0, -1, 8'h00, 0, 0, 1, 0);
    check("err_set", err_tlast, 1);
    repeat (5) begin @(posedge ce_clk); #1; end
    check("err_sticky", err_tlast, 1);
    clear_err = 1'b1;
    @(posedge ce_clk); #1;
    clear_err = 1'b0;
    check("err_cleared", err_tlast, 0);
    send_symbol(6500, 63, 0, -1, 8'h00, 0, 1, 1, 0);
    check("err_clear_collide", err_tlast, 1);
    wait_drain();
    clear_err = 1'b1;
    @(posedge ce_clk); #1;
    clear_err = 1'b0;

    // Asynchronous reset mid-symbol while a previous symbol is still streaming out.
    wr_set(8'h11, 4);
    send_symbol(8000, 5, 0, -1, 8'h00, 0, 0, 1, 0);
    send_symbol(9000, -1, 0, -1, 8'h00, 0, 0, 0, 30);
    check("pre_rst_err", err_tlast, 1);
    check("pre_rst_busy", out_if.tvalid, 1);
    #2 ce_rst = 1'b0;
    #1;
    check("arst_o_tvalid", out_if.tvalid, 0);
    check("arst_o_tlast", out_if.tlast, 0);
    check("arst_o_tdata", out_if.tdata, 0);
    check("arst_i_tready", in_if.tready, 0);
    check("arst_err", err_tlast, 0);
    exp_q.delete();
    sym_in = 0;
    sym_out = 0;
    mdl_flen = 64;
    mdl_cp = 16;
    repeat (2) @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst = 1'b1;
    @(posedge ce_clk); #1;
    check("post_rst_rdy", in_if.tready, 1);
    win_n = 0;
    send(7000);
    wait_drain();
    check("post_rst_count", win_n, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ofdm_cp_inserter.md
Name: ofdm_cp_inserter

Overview:
- Transmit-side counterpart of the Schmidl-Cox receive chain's periodic framer (which strips the CP). Accepts OFDM symbols of frame_len complex samples on AXI-Stream and emits, per symbol, a cyclic prefix (last cp_len samples) followed by the full symbol.
- Sits after the IFFT in a TX RFNoC block and uses the same settings-bus register map as the RX framer: 0x10 = frame_len, 0x11 = cp_len.
- Ping-pong symbol buffering sustains full throughput.

Parameters:
- WIDTH, 32: sample width (sc16 IQ).
- MAX_LEN_LOG2, 12: log2 of the largest frame_len; each bank holds 2^MAX_LEN_LOG2 samples.
- SR_FRAME_LEN, 8'h10: settings address for frame_len.
- SR_CP_LEN, 8'h11: settings address for cp_len.

Ports:
- ce_clk  in  1  clock.
- ce_rst  in  1  reset, asynchronous, active-low.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  WIDTH  input sample.
- i_tlast  in  1  input end-of-symbol marker (checked only).
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output sample.
- o_tlast  out  1  high on the last sample of each CP+symbol.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- err_tlast  out  1  sticky flag: i_tlast did not coincide with the frame_len-th input sample.
- clear_err  in  1  clears err_tlast.

Behaviour:
- Reset (ce_rst=0, async):
  - Outputs: i_tready=0, o_tvalid=0, o_tlast=0, o_tdata=0, err_tlast=0.
  - Registers: frame_len=64, cp_len=16.
  - Both banks empty; write and read pointers at bank 0.
  - Reset asserted mid-symbol discards all buffered data.
  - i_tready rises 1 cycle after reset release.
- Settings writes:
  - frame_len: valid range 1..2^MAX_LEN_LOG2. A write of 0 or an out-of-range value is ignored.
  - cp_len: 0..frame_len.
  - Lengths are snapshotted into a bank's descriptor when the first sample of that bank is written. A write mid-symbol affects only the next symbol.
  - The effective CP length is min(cp_len, frame_len), evaluated at snapshot time.
- Write side:
  - i_tready = current write bank not full.
  - Each i_tvalid&&i_tready writes the sample at address wr_cnt, then wr_cnt increments.
  - When wr_cnt = flen-1 the bank is marked full, wr_cnt resets to 0 and the write bank toggles.
  - Symbols are framed by count only; i_tlast is not used for framing.
  - If i_tlast is high on a non-final sample, or low on the final sample, err_tlast is set. The data is still used.
- Read FSM, states IDLE, CP, BODY:
  - IDLE: when the read bank is full, go to CP with rd_addr = flen-cplen. If cplen = 0, go directly to BODY with rd_addr = 0.
  - CP: advance rd_addr on each accepted read; after the address flen-1 is issued, go to BODY with rd_addr = 0.
  - BODY: advance rd_addr; after the address flen-1 is issued, mark the bank empty, toggle the read bank, and go to CP if the other bank is full, else IDLE.
  - RAM read latency is 1 cycle. A 2-entry output skid buffer carries o_tdata/o_tlast, so reads are issued only while the skid buffer has space.
  - The output obeys AXI-Stream: o_tdata and o_tlast are held while o_tvalid && !o_tready.
- Latency and throughput:
  - First output sample appears 2 cycles after the final input sample of a symbol is accepted, given o_tready=1.
  - Back-to-back symbols output with no idle cycles (flen+cplen samples per flen input samples). The input stalls when both banks are full.
- Simultaneous events:
  - Bank-full set by the writer and bank-empty cleared by the reader in the same cycle target different banks and are independent.
  - clear_err and a new error in the same cycle leave err_tlast=1.
  - A settings write in the same cycle as a snapshot: the snapshot uses the old value.

Decomposition:
- Shared package cp_inserter_pkg: SR_FRAME_LEN/SR_CP_LEN addresses, default lengths (64, 16), MAX_LEN_LOG2, FSM state enum, bank-descriptor struct {flen, cplen}.
- One sub-module: cp_pingpong_ram, a simple dual-port RAM of 2×2^MAX_LEN_LOG2 × WIDTH with a 1-cycle registered read. Bank select is the address MSB.

Test Plan:
- frame_len=64, cp_len=16, input ramp 0..63 with i_tlast on 63, o_tready=1 -> 80 outputs: 48..63 then 0..63, o_tlast only on the 80th; err_tlast=0.
- 4 back-to-back symbols (ramps offset by 100·k), o_tready=1 -> 320 contiguous outputs with no o_tvalid gaps after the first; correct CP per symbol.
- Random o_tready (50%) and random i_tvalid -> output sequence identical to the previous test; data held stable during stalls; i_tready low only when both banks are full.
- cp_len=0 -> 64-sample pass-through; cp_len=8 with frame_len=8 -> each symbol emitted twice (16 samples); a cp_len=20 write during a symbol -> applies from the next symbol only.
- i_tlast asserted on sample 10 -> err_tlast=1 and stays high; clear_err -> 0; output data unaffected.
- ce_rst pulsed low after 30 of 64 input samples -> outputs return to reset values asynchronously; the next full symbol after release produces exactly 80 correct outputs.
